// File: rtl/biriscv_issue_queue.sv
// ----------------------------------------------------------------------------
// biriscv_issue_queue
//   Dual-slot in, dual-slot out circular issue queue between decode/fetch and
//   the issue stage. Up to two decoded instructions are written per cycle and
//   up to two are consumed per cycle, always in program order.
//
//   Ports
//     clk_i, rst_i             clock, asynchronous active-high reset
//     flush_i                  redirect: discard every entry and same-cycle enqueue
//     fetch{0,1}_valid_i       decoded slot valid
//     fetch{0,1}_instr_i       instruction word (32)
//     fetch{0,1}_pc_i          instruction PC (32)
//     fetch{0,1}_fault_i       {fault_page, fault_fetch}
//     fetch{0,1}_info_i        {lsu_v, invalid, rd_valid, csr, div, mul, branch, lsu, exec}
//     fetch{0,1}_accept_o      slot accepted this cycle
//     issue{0,1}_valid_o       head / head+1 entry present
//     issue{0,1}_instr/pc/fault/info_o  entry payload, zero when not valid
//     issue{0,1}_accept_i      issue stage consumes the entry
//     level_o                  current occupancy
// ----------------------------------------------------------------------------
module biriscv_issue_queue #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned DEPTH_W = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               flush_i,

    input  logic               fetch0_valid_i,
    input  logic [31:0]        fetch0_instr_i,
    input  logic [31:0]        fetch0_pc_i,
    input  logic [1:0]         fetch0_fault_i,
    input  logic [8:0]         fetch0_info_i,
    output logic               fetch0_accept_o,

    input  logic               fetch1_valid_i,
    input  logic [31:0]        fetch1_instr_i,
    input  logic [31:0]        fetch1_pc_i,
    input  logic [1:0]         fetch1_fault_i,
    input  logic [8:0]         fetch1_info_i,
    output logic               fetch1_accept_o,

    output logic               issue0_valid_o,
    output logic [31:0]        issue0_instr_o,
    output logic [31:0]        issue0_pc_o,
    output logic [1:0]         issue0_fault_o,
    output logic [8:0]         issue0_info_o,
    input  logic               issue0_accept_i,

    output logic               issue1_valid_o,
    output logic [31:0]        issue1_instr_o,
    output logic [31:0]        issue1_pc_o,
    output logic [1:0]         issue1_fault_o,
    output logic [8:0]         issue1_info_o,
    input  logic               issue1_accept_i,

    output logic [DEPTH_W:0]   level_o
);

    localparam int unsigned CNT_W = DEPTH_W + 1;

    // One queue entry: 75 bits of payload.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [1:0]  fault;
        logic [8:0]  info;
    } entry_t;

    entry_t               ram_q [DEPTH];
    logic [DEPTH_W-1:0]   wr_ptr_q;
    logic [DEPTH_W-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]     count_q;

    logic                 enq0;
    logic                 enq1;
    logic                 deq0;
    logic                 deq1;
    logic [1:0]           enq_n;
    logic [1:0]           deq_n;
    logic [DEPTH_W-1:0]   wr1_idx;
    logic [DEPTH_W-1:0]   rd1_idx;
    entry_t               slot0;
    entry_t               slot1;
    entry_t               head0;
    entry_t               head1;

    // Accept credit comes only from the pre-dequeue occupancy, so a write can
    // never land on an entry that is still live.
    always_comb begin
        fetch0_accept_o = (count_q <= CNT_W'(DEPTH - 1));
        fetch1_accept_o = (count_q <= CNT_W'(DEPTH - 2));
        issue0_valid_o  = (count_q >= CNT_W'(1));
        issue1_valid_o  = (count_q >= CNT_W'(2));
        level_o         = count_q;
    end

    // Handshakes; head+1 may only leave together with the head.
    always_comb begin
        enq0  = fetch0_valid_i & fetch0_accept_o;
        enq1  = fetch1_valid_i & fetch1_accept_o;
        deq0  = issue0_valid_o & issue0_accept_i;
        deq1  = deq0 & issue1_valid_o & issue1_accept_i;
        enq_n = {1'b0, enq0} + {1'b0, enq1};
        deq_n = {1'b0, deq0} + {1'b0, deq1};
    end

    // Slot1 follows slot0 when both write, otherwise takes wr_ptr itself.
    always_comb begin
        wr1_idx = wr_ptr_q + DEPTH_W'(enq0);
        rd1_idx = rd_ptr_q + DEPTH_W'(1);
    end

    // Pack incoming slots into entries.
    always_comb begin
        slot0.instr = fetch0_instr_i;
        slot0.pc    = fetch0_pc_i;
        slot0.fault = fetch0_fault_i;
        slot0.info  = fetch0_info_i;
        slot1.instr = fetch1_instr_i;
        slot1.pc    = fetch1_pc_i;
        slot1.fault = fetch1_fault_i;
        slot1.info  = fetch1_info_i;
    end

    // Read straight from storage; payloads are blanked when the entry is absent.
    always_comb begin
        head0 = '0;
        head1 = '0;
        if (issue0_valid_o) begin
            head0 = ram_q[rd_ptr_q];
        end
        if (issue1_valid_o) begin
            head1 = ram_q[rd1_idx];
        end
        issue0_instr_o = head0.instr;
        issue0_pc_o    = head0.pc;
        issue0_fault_o = head0.fault;
        issue0_info_o  = head0.info;
        issue1_instr_o = head1.instr;
        issue1_pc_o    = head1.pc;
        issue1_fault_o = head1.fault;
        issue1_info_o  = head1.info;
    end

    // Pointer and occupancy state. A flush wins over any same-cycle traffic.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_q + DEPTH_W'(enq_n);
            rd_ptr_q <= rd_ptr_q + DEPTH_W'(deq_n);
            count_q  <= count_q + CNT_W'(enq_n) - CNT_W'(deq_n);
        end
    end

    // Entry storage; flushed writes are dropped since they could never issue.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                ram_q[i] <= '0;
            end
        end else if (!flush_i) begin
            if (enq0) begin
                ram_q[wr_ptr_q] <= slot0;
            end
            if (enq1) begin
                ram_q[wr1_idx] <= slot1;
            end
        end
    end

endmodule
